// File: rtl/nibble_serial_adder_if.sv
// Operand/result bus of the nibble-serial adder.
// Optional port ovf exists only when SERIAL_ADD_OVF_EN is defined.
interface nibble_serial_adder_if #(
    parameter int WIDTH = 16
);
    // Valid/ready: a transfer happens on a rising edge where valid && ready.
    // The producer keeps its payload stable while valid is high and ready is
    // low. The consumer may change ready at any time.
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
`ifdef SERIAL_ADD_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
`ifdef SERIAL_ADD_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that reuses one 4-bit full-adder slice, one nibble per clock, LSB first.
// Define SERIAL_ADD_OVF_EN to add the registered signed-overflow output ovf.
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    nibble_serial_adder_if.slave   bus,
    output logic [1:0]             dbg_state
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf_q;
`endif

    // Returns {carry into bit 3, carry out of bit 3, 4-bit sum}.
    function automatic logic [5:0] slice4(input logic [3:0] x, input logic [3:0] y,
                                          input logic ci);
        logic [4:0] c;
        logic [3:0] s;
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < 4; i++) begin
            s[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
        return {c[3], c[4], s};
    endfunction

    logic [5:0]       slice;
    logic [3:0]       slice_s;
    logic             slice_co;
    logic             slice_c3;
    logic [WIDTH-1:0] acc_nxt;

    always_comb begin
        slice    = slice4(a_sh[3:0], b_sh[3:0], carry);
        slice_s  = slice[3:0];
        slice_co = slice[4];
        slice_c3 = slice[5];
        // New nibble enters at the top; after NIB shifts acc holds the full sum.
        acc_nxt  = (acc >> 4) | (WIDTH'(slice_s) << (WIDTH - 4));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            acc    <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sh  <= bus.a;
                        b_sh  <= bus.b;
                        carry <= bus.cin;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 4;
                    b_sh  <= b_sh >> 4;
                    acc   <= acc_nxt;
                    carry <= slice_co;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        sum_q  <= acc_nxt;
                        cout_q <= slice_co;
`ifdef SERIAL_ADD_OVF_EN
                        ovf_q  <= slice_c3 ^ slice_co;
`endif
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    assign bus.ovf       = ovf_q;
`else
    // Carry into the MSB only feeds the optional overflow flag.
    logic unused_c3;
    assign unused_c3 = slice_c3;
`endif
    assign dbg_state     = state;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder: arithmetic, latency, backpressure, mid-op reset.
// Compile with SERIAL_ADD_OVF_EN defined to also exercise the ovf output.
module tb_nibble_serial_adder;
  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         n_vec;
  int         n_err;
  logic [15:0] prev_sum;
  logic [16:0] exp_q[$];

  nibble_serial_adder_if #(.WIDTH(16)) bus ();

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accept one add, watch the run, check latency and result, then release it.
  task automatic do_add(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                        input logic [15:0] exp_sum, input logic exp_cout, input string name);
    int          cyc;
    bit          seen;
    logic [16:0] exp;
    @(negedge clk);
    n_vec++;
    if (bus.in_ready !== 1'b1) begin
      n_err++; $display("FAIL %s idle_in_ready: got %b want 1", name, bus.in_ready);
    end
    bus.a = ta; bus.b = tb_v; bus.cin = tc; bus.in_valid = 1'b1;
    exp_q.push_back({exp_cout, exp_sum});
    @(posedge clk);
    #1;
    // Operand changes after acceptance must not matter.
    bus.in_valid = 1'b0; bus.a = 16'hDEAD; bus.b = 16'hBEEF; bus.cin = 1'b1;
    cyc = 0; seen = 0;
    while (cyc < 20 && !seen) begin
      @(negedge clk);
      cyc++;
      if (bus.out_valid === 1'b1) seen = 1;
      else begin
        n_vec++;
        if (bus.in_ready !== 1'b0) begin
          n_err++; $display("FAIL %s run_in_ready cyc%0d: got %b want 0", name, cyc, bus.in_ready);
        end
        n_vec++;
        if (bus.sum !== prev_sum) begin
          n_err++; $display("FAIL %s run_sum_hold cyc%0d: got %h want %h", name, cyc, bus.sum, prev_sum);
        end
      end
    end
    n_vec++;
    if (!seen) begin
      n_err++; $display("FAIL %s timeout: got no out_valid want out_valid within 20 cycles", name);
      void'(exp_q.pop_front());
    end else begin
      // First sample falls before edge k+1, so out_valid after edge k+4 is sample 5.
      if (cyc != 5) begin
        n_err++; $display("FAIL %s latency: got %0d want 5", name, cyc);
      end
      exp = exp_q.pop_front();
      n_vec++;
      if (bus.sum !== exp[15:0]) begin
        n_err++; $display("FAIL %s sum: got %h want %h", name, bus.sum, exp[15:0]);
      end
      n_vec++;
      if (bus.cout !== exp[16]) begin
        n_err++; $display("FAIL %s cout: got %b want %b", name, bus.cout, exp[16]);
      end
      prev_sum = exp[15:0];
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    prev_sum = '0;
    #12;
    n_vec++;
    if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    n_vec++;
    if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_vec++;
    if (bus.sum !== 16'h0000) begin n_err++; $display("FAIL reset_sum: got %h want 0000", bus.sum); end
    n_vec++;
    if (bus.cout !== 1'b0) begin n_err++; $display("FAIL reset_cout: got %b want 0", bus.cout); end
`ifdef SERIAL_ADD_OVF_EN
    n_vec++;
    if (bus.ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", bus.ovf); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    do_add(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, "basic");
  endtask

  task automatic test_nibble_carry();
    do_add(16'h000F, 16'h0001, 1'b0, 16'h0010, 1'b0, "carry_n0");
    do_add(16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0, "carry_cin");
  endtask

  task automatic test_full_chain();
    do_add(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, "chain_ff01");
    do_add(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, "chain_ffff");
    do_add(16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1, "chain_a55a");
  endtask

  task automatic test_backpressure();
    int cyc;
    @(negedge clk);
    bus.a = 16'h0102; bus.b = 16'h0304; bus.cin = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    cyc = 0;
    while (cyc < 20 && bus.out_valid !== 1'b1) begin
      @(negedge clk);
      cyc++;
    end
    n_vec++;
    if (bus.out_valid !== 1'b1) begin
      n_err++; $display("FAIL bp_timeout: got out_valid %b want 1", bus.out_valid);
    end
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      n_vec++;
      if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_out_valid c%0d: got %b want 1", i, bus.out_valid); end
      n_vec++;
      if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready c%0d: got %b want 0", i, bus.in_ready); end
      n_vec++;
      if (bus.sum !== 16'h0406) begin n_err++; $display("FAIL bp_sum c%0d: got %h want 0406", i, bus.sum); end
      n_vec++;
      if (bus.cout !== 1'b0) begin n_err++; $display("FAIL bp_cout c%0d: got %b want 0", i, bus.cout); end
      bus.a = 16'h1111; bus.b = 16'h1111;
      bus.in_valid = (i % 2 == 0) && (i < 8);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_in_ready: got %b want 1", bus.in_ready); end
    n_vec++;
    if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_out_valid: got %b want 0", bus.out_valid); end
    n_vec++;
    if (bus.sum !== 16'h0406) begin n_err++; $display("FAIL bp_release_sum: got %h want 0406", bus.sum); end
    // The ignored 0x1111 operands must not surface as a ghost result.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_vec++;
      if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_ghost c%0d: got %b want 0", i, bus.out_valid); end
    end
    prev_sum = 16'h0406;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.a = 16'h1111; bus.b = 16'h2222; bus.cin = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_vec++;
    if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_out_valid: got %b want 0", bus.out_valid); end
    n_vec++;
    if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rmid_in_ready: got %b want 1", bus.in_ready); end
    n_vec++;
    if (bus.sum !== 16'h0000) begin n_err++; $display("FAIL rmid_sum: got %h want 0000", bus.sum); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_vec++;
      if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_no_result c%0d: got %b want 0", i, bus.out_valid); end
    end
    prev_sum = 16'h0000;
    do_add(16'h0002, 16'h0003, 1'b0, 16'h0005, 1'b0, "rmid_after");
  endtask

`ifdef SERIAL_ADD_OVF_EN
  task automatic test_ovf();
    do_add(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, "ovf_pos");
    n_vec++;
    if (bus.ovf !== 1'b1) begin n_err++; $display("FAIL ovf_pos_flag: got %b want 1", bus.ovf); end
    do_add(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, "ovf_neg");
    n_vec++;
    if (bus.ovf !== 1'b1) begin n_err++; $display("FAIL ovf_neg_flag: got %b want 1", bus.ovf); end
    do_add(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, "ovf_none");
    n_vec++;
    if (bus.ovf !== 1'b0) begin n_err++; $display("FAIL ovf_none_flag: got %b want 0", bus.ovf); end
  endtask
`endif

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_nibble_carry();
    test_full_chain();
    test_backpressure();
    test_reset_mid();
`ifdef SERIAL_ADD_OVF_EN
    test_ovf();
`endif
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL leftover_expected: got %0d want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
Multi-cycle WIDTH-bit adder that time-multiplexes one 4-bit ripple-carry slice built from full adders. It processes one nibble per clock, LSB first, with the carry registered between nibbles. It sits between an operand source and a result consumer, with valid/ready handshakes on both sides. It is the area-reduced alternative to the fully unrolled 16-bit ripple adder.

Parameters:
WIDTH, 16, operand/sum width in bits; must be a multiple of 4 and at least 4.
NIB, WIDTH/4, number of nibble cycles per add (localparam, not overridable).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands a/b/cin present
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in to the LSB nibble
out_valid  output  1  sum/cout valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  A+B+cin, low WIDTH bits
cout  output  1  carry-out of the MSB nibble

Behaviour:
- One clock. Reset is asynchronous, active-low: clk, rst_n.
- Reset values (immediate on rst_n=0): state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, internal shift registers, carry and counter=0.
- States: IDLE, RUN, DONE. in_ready is 1 only in IDLE. out_valid is 1 only in DONE. Both are decoded from registered state.
- IDLE: on in_valid&&in_ready at an edge, latch a, b and cin into a_sh, b_sh and carry, set cnt=0, and go to RUN. Otherwise stay in IDLE.
- RUN, each cycle:
  - The slice adds a_sh[3:0]+b_sh[3:0]+carry.
  - The 4-bit result shifts into the top of acc; acc shifts right 4.
  - a_sh and b_sh shift right 4; carry takes the slice carry-out; cnt increments.
  - When cnt==NIB-1, load sum<=final acc and cout<=slice carry-out on that edge, then go to DONE.
- Latency: operands accepted at edge k give out_valid=1 after edge k+NIB. For WIDTH=16 that is 4 cycles.
- DONE: sum and cout hold stable while out_ready=0. On out_ready=1 at an edge, go to IDLE with out_valid=0. Throughput is one add per NIB+2 cycles.
- sum and cout change only on entry to DONE. Between results they keep the last completed value.
- Operands are sampled only at acceptance. Changes on a/b/cin afterwards have no effect.
- in_valid outside IDLE is ignored; no queuing.
- out_ready outside DONE is ignored.
- Arithmetic: unsigned, modulo 2^WIDTH. cout is the true carry-out, identical to a single-cycle WIDTH-bit ripple add.
- Reset mid-RUN or mid-DONE: the operation is discarded and no result is emitted. After release the block is in IDLE with in_ready=1.
- The first accept is possible on the first rising edge after rst_n deasserts.

Optional Feature:
SERIAL_ADD_OVF_EN
- Defined:
  - Adds output port ovf (1 bit, registered).
  - ovf = carry into the MSB bit XOR cout, i.e. two's-complement signed overflow.
  - It is computed during the final nibble cycle and loaded alongside sum.
  - Reset value 0; it holds with sum.
- Undefined:
  - The ovf port is absent; no extra logic.

Test Plan:
- Basic add: a=0x1234, b=0x4321, cin=0 -> sum=0x5555, cout=0. out_valid rises exactly 4 cycles after accept, and in_ready=0 during those cycles.
- Inter-nibble carry: a=0x000F, b=0x0001, cin=0 -> sum=0x0010, cout=0. Then a=0x0FFF, b=0x0000, cin=1 -> sum=0x1000, cout=0.
- Full carry chain: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1. Then a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE and pulse in_valid with a=0x1111 -> sum and cout stay stable, in_ready=0, and the operand is ignored. After out_ready=1, in_ready returns to 1 the next cycle.
- Reset mid-operation: assert rst_n=0 two cycles into RUN -> out_valid=0, sum=0 and in_ready=1 immediately. No result appears after release, and a new add of 0x0002+0x0003 yields sum=0x0005.
- With SERIAL_ADD_OVF_EN: 0x7FFF+0x0001 -> sum=0x8000, ovf=1, cout=0. 0x8000+0x8000 -> sum=0x0000, cout=1, ovf=1. 0x1234+0x4321 -> ovf=0.
